// File: rtl/mk_blur3x3.sv
// 3x3 binomial blur (1-2-1 / 2-4-2 / 1-2-1, divide by 16) over a raster greyscale stream.
// Two single-line buffers feed the top rows of the window; HSync blanking clears the window and column.
module mk_blur3x3 #(
  parameter int WIDTH = 640
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       HSync,
  input  logic [7:0] gry_in,
  output logic [7:0] gry_out
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int AW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] COL_END = CW'(WIDTH);

  logic [7:0]             l1 [WIDTH];
  logic [7:0]             l2 [WIDTH];
  logic [CW-1:0]          col;
  logic [AW-1:0]          addr;
  logic                   in_line;
  logic [2:0][2:0][7:0]   win;
  logic [2:0][7:0]        fresh;
  logic [11:0]            sum;

  assign addr    = col[AW-1:0];
  assign in_line = (col < COL_END);

  // Column entering the window; pixels past the line width contribute zeros.
  always_comb begin
    fresh = '0;
    if (in_line) begin
      fresh[0] = l2[addr];
      fresh[1] = l1[addr];
      fresh[2] = gry_in;
    end
  end

  // Buffers carry no reset; writes are held off while reset keeps col pinned at 0.
  always_ff @(posedge CLK) begin
    if (RST_N && !HSync && in_line) begin
      l2[addr] <= l1[addr];
      l1[addr] <= gry_in;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      col <= '0;
      win <= '0;
    end else if (HSync) begin
      col <= '0;
      win <= '0;
    end else begin
      for (int unsigned r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
        win[r][2] <= fresh[r];
      end
      if (in_line) col <= col + CW'(1);
    end
  end

  // Weight is 2^(centre-row + centre-column), giving the 1-2-1 outer product.
  always_comb begin
    sum = '0;
    for (int unsigned r = 0; r < 3; r++) begin
      for (int unsigned c = 0; c < 3; c++) begin
        sum = sum + (12'(win[r][c]) << ((r == 1 ? 1 : 0) + (c == 1 ? 1 : 0)));
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) gry_out <= '0;
    else        gry_out <= 8'(sum >> 4);
  end

endmodule
